// File: rtl/adv7513_dump_pkg.sv
// Shared types and constants for the ADV7513 register-dump sequencer.
// ADV7513_DUMP_ADDR_TAG_EN selects two stream bytes (address, data) per register.
package adv7513_dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PUSH,
        S_NEXT,
        S_DRAIN
    } dump_state_t;

    localparam logic [7:0] DUMP_ERR_BYTE   = 8'hFF;
    localparam int         DUMP_FIFO_DEPTH = 4;

    // FIFO entries written per register
`ifdef ADV7513_DUMP_ADDR_TAG_EN
    localparam logic [2:0] DUMP_REC_LEN = 3'd2;
`else
    localparam logic [2:0] DUMP_REC_LEN = 3'd1;
`endif

endpackage

// File: rtl/adv7513_dump_fifo.sv
// Four-entry first-word-fall-through byte FIFO for the register dump stream.
// ADV7513_DUMP_ADDR_TAG_EN adds a second write port written in the same cycle.
module adv7513_dump_fifo
    import adv7513_dump_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
`ifdef ADV7513_DUMP_ADDR_TAG_EN
    input  logic [7:0] wr_data2,
`endif
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       valid,
    output logic [2:0] count,
    output logic [2:0] free
);

    logic [7:0] mem [DUMP_FIFO_DEPTH];
    logic [1:0] wr_ptr_reg;
    logic [1:0] rd_ptr_reg;
    logic [2:0] count_reg;
    logic       pop;

    assign pop = rd_en && (count_reg != 3'd0);

    // Storage is not reset; empty entries are masked at the output instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
`ifdef ADV7513_DUMP_ADDR_TAG_EN
            mem[wr_ptr_reg + 2'd1] <= wr_data2;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + 2'(DUMP_REC_LEN);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            count_reg <= count_reg + (wr_en ? DUMP_REC_LEN : 3'd0) - (pop ? 3'd1 : 3'd0);
        end
    end

    assign valid   = (count_reg != 3'd0);
    assign rd_data = valid ? mem[rd_ptr_reg] : 8'h00;
    assign count   = count_reg;
    assign free    = 3'(DUMP_FIFO_DEPTH) - count_reg;

endmodule

// File: rtl/adv7513_reg_dump.sv
// Walks an ADV7513 register range through the read stage and streams the bytes out.
// ADV7513_DUMP_ADDR_TAG_EN prefixes each data byte with its register address.
module adv7513_reg_dump
    import adv7513_dump_pkg::*;
#(
    parameter logic [7:0]  START_ADDR     = 8'h00,
    parameter logic [7:0]  END_ADDR       = 8'hFF,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    output logic       busy,
    output logic       finished,
    output logic       err,
    output logic       rd_start,
    output logic [7:0] rd_addr,
    input  logic       rd_done,
    input  logic [7:0] rd_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready
);

    dump_state_t state_reg;
    logic [7:0]  cur_reg;
    logic [7:0]  cap_reg;
    logic [23:0] tcnt_reg;
    logic        done_q_reg;
    logic        busy_reg;
    logic        finished_reg;
    logic        err_reg;
    logic        rd_start_reg;

    logic [2:0]  fifo_count;
    logic [2:0]  fifo_free;
    logic        push;
    logic        completion;

    assign completion = rd_done && !done_q_reg;
    assign push       = (state_reg == S_PUSH) && (fifo_free >= DUMP_REC_LEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            cur_reg      <= START_ADDR;
            cap_reg      <= 8'h00;
            tcnt_reg     <= 24'd0;
            done_q_reg   <= 1'b1;
            busy_reg     <= 1'b0;
            finished_reg <= 1'b0;
            err_reg      <= 1'b0;
            rd_start_reg <= 1'b0;
        end else begin
            done_q_reg   <= rd_done;
            rd_start_reg <= 1'b0;
            finished_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (go) begin
                        cur_reg      <= START_ADDR;
                        err_reg      <= 1'b0;
                        busy_reg     <= 1'b1;
                        rd_start_reg <= 1'b1;
                        state_reg    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tcnt_reg  <= 24'd0;
                    state_reg <= S_WAIT;
                end
                // A completion in the same cycle as the timeout takes priority.
                S_WAIT: begin
                    if (completion) begin
                        cap_reg   <= rd_data;
                        state_reg <= S_PUSH;
                    end else if (tcnt_reg == TIMEOUT_CYCLES - 24'd1) begin
                        cap_reg   <= DUMP_ERR_BYTE;
                        err_reg   <= 1'b1;
                        state_reg <= S_PUSH;
                    end else begin
                        tcnt_reg <= tcnt_reg + 24'd1;
                    end
                end
                S_PUSH: begin
                    if (push)
                        state_reg <= S_NEXT;
                end
                S_NEXT: begin
                    if (cur_reg == END_ADDR) begin
                        state_reg <= S_DRAIN;
                    end else begin
                        cur_reg      <= cur_reg + 8'd1;
                        rd_start_reg <= 1'b1;
                        state_reg    <= S_ISSUE;
                    end
                end
                S_DRAIN: begin
                    if (fifo_count == 3'd0) begin
                        finished_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                        state_reg    <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    adv7513_dump_fifo u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (push),
`ifdef ADV7513_DUMP_ADDR_TAG_EN
        .wr_data  (cur_reg),
        .wr_data2 (cap_reg),
`else
        .wr_data  (cap_reg),
`endif
        .rd_en    (byte_ready),
        .rd_data  (byte_data),
        .valid    (byte_valid),
        .count    (fifo_count),
        .free     (fifo_free)
    );

    assign busy     = busy_reg;
    assign finished = finished_reg;
    assign err      = err_reg;
    assign rd_start = rd_start_reg;
    assign rd_addr  = cur_reg;

endmodule
